// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: glyph patterns (bit 6 = A .. bit 0 = G, lit = 1)
// and lock FSM state encodings, used by the decoder and the binary-to-segment encoder.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] GLYPHS [16] = '{
    7'h7E,  // 0 ABCDEF
    7'h30,  // 1 BC
    7'h6D,  // 2 ABDEG
    7'h79,  // 3 ABCDG
    7'h33,  // 4 BCFG
    7'h5B,  // 5 ACDFG
    7'h5F,  // 6 ACDEFG
    7'h70,  // 7 ABC
    7'h7F,  // 8 ABCDEFG
    7'h7B,  // 9 ABCDFG
    7'h77,  // A ABCEFG
    7'h1F,  // b CDEFG
    7'h4E,  // C ADEF
    7'h3D,  // d BCDEG
    7'h4F,  // E ADEFG
    7'h47   // F AEFG
  };

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } lock_state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    return GLYPHS[digit];
  endfunction

endpackage

// File: rtl/segment_glyph_lookup.sv
// Combinational reverse lookup from a lit-high 7-bit segment pattern to its hex digit.
module segment_glyph_lookup
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       match,
  output logic       blank
);

  always_comb begin
    digit = 4'd0;
    match = 1'b0;
    blank = (pattern == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPHS[i]) begin
        digit = 4'(i);
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/segment_pattern_decoder.sv
// Debounces raw seven-segment lines, commits a pattern once it has been stable long
// enough, and reports the decoded hex digit plus a change pulse and change counter.
module segment_pattern_decoder
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  output logic [3:0] o_Digit,
  output logic       o_Valid,
  output logic       o_Blank,
  output logic       o_Invalid,
  output logic       o_Update,
  output logic [7:0] o_Update_Count
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES - 1);

  logic [6:0]  raw_pattern;
  logic [6:0]  lit_pattern;
  logic [6:0]  sync_meta;
  logic [6:0]  sample;
  logic [6:0]  candidate;
  logic [6:0]  committed;
  logic [7:0]  stable_count;
  lock_state_t state;
  lock_state_t state_next;
  logic        commit;
  logic        first_commit;
  logic [3:0]  lookup_digit;
  logic        lookup_match;
  logic        lookup_blank;

  assign raw_pattern  = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                         i_Segment_E, i_Segment_F, i_Segment_G};
  assign lit_pattern  = ACTIVE_LOW ? ~raw_pattern : raw_pattern;
  // No status flag is set until the first commit, so this marks "nothing committed yet".
  assign first_commit = ~(o_Valid | o_Blank | o_Invalid);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_meta <= 7'd0;
      sample    <= 7'd0;
    end else begin
      sync_meta <= lit_pattern;
      sample    <= sync_meta;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      candidate    <= 7'd0;
      stable_count <= 8'd0;
    end else if (sample != candidate) begin
      candidate    <= sample;
      stable_count <= 8'd0;
    end else if (stable_count != STABLE_MAX) begin
      stable_count <= stable_count + 8'd1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= ACQUIRE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      ACQUIRE: begin
        if (stable_count == STABLE_MAX && sample == candidate) begin
          commit     = 1'b1;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (sample != candidate) begin
          state_next = ACQUIRE;
        end
      end
      default: state_next = ACQUIRE;
    endcase
  end

  segment_glyph_lookup u_lookup (
    .pattern (candidate),
    .digit   (lookup_digit),
    .match   (lookup_match),
    .blank   (lookup_blank)
  );

  // A re-commit of the same pattern (glitch that settled back) refreshes nothing visible.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      committed      <= 7'd0;
      o_Digit        <= 4'd0;
      o_Valid        <= 1'b0;
      o_Blank        <= 1'b0;
      o_Invalid      <= 1'b0;
      o_Update       <= 1'b0;
      o_Update_Count <= 8'd0;
    end else begin
      o_Update <= 1'b0;
      if (commit) begin
        committed <= candidate;
        o_Valid   <= lookup_match;
        o_Blank   <= lookup_blank;
        o_Invalid <= ~lookup_match & ~lookup_blank;
        if (lookup_match) begin
          o_Digit <= lookup_digit;
        end
        if (first_commit || candidate != committed) begin
          o_Update       <= 1'b1;
          o_Update_Count <= o_Update_Count + 8'd1;
        end
      end
    end
  end

endmodule
